reduction_accumulator: RTL and testbench

Streaming reduction unit that folds a packet of WIDTH-bit words into one set of six reduction results: AND, NAND, OR, NOR, XOR and XNOR across every bit of every word in the packet. The unit sits between a valid/ready word source and a valid/ready result sink, and is the packetised, parametrised successor of the single-word combinational reduction block. It also reports the word count, and a truncation flag when a packet exceeds MAX_WORDS.

---
 rtl/reduction_accumulator_pkg.sv | 30 +++
 rtl/reduction_accumulator_if.sv | 43 ++++
 rtl/reduction_accumulator_word.sv | 15 +
 rtl/reduction_accumulator.sv | 102 ++++++++++
 tb/tb_reduction_accumulator.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/reduction_accumulator_pkg.sv
// Shared constants for the packetised reduction unit: result bit indices,
// FSM encodings, result reset value and a helper that expands the three base reductions.
package reduction_pkg;

  localparam int RED_AND  = 5;
  localparam int RED_NAND = 4;
  localparam int RED_OR   = 3;
  localparam int RED_NOR  = 2;
  localparam int RED_XOR  = 1;
  localparam int RED_XNOR = 0;

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [5:0] RED_RST = 6'b010101;

  // Complement bits are always derived from their base reduction.
  function automatic logic [5:0] pack_red(input logic a, input logic o, input logic x);
    logic [5:0] r;
    r           = '0;
    r[RED_AND]  = a;
    r[RED_NAND] = ~a;
    r[RED_OR]   = o;
    r[RED_NOR]  = ~o;
    r[RED_XOR]  = x;
    r[RED_XNOR] = ~x;
    return r;
  endfunction

endpackage

// File: rtl/reduction_accumulator_if.sv
// Word-in / result-out bundle for reduction_accumulator.
// Optional parity ports appear when PARITY_CHECK_EN is defined.
interface reduction_accumulator_if #(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 16
);
  localparam int CW = $clog2(MAX_WORDS + 1);

  // Both channels are valid/ready: a transfer happens on a rising clk edge where
  // valid && ready; the source holds payload stable while valid && !ready.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       out_red;
  logic [CW-1:0]    out_count;
  logic             out_trunc;
`ifdef PARITY_CHECK_EN
  logic             in_par_exp;
  logic             out_par_err;

  modport slave (
    input  in_valid, in_data, in_last, out_ready, in_par_exp,
    output in_ready, out_valid, out_red, out_count, out_trunc, out_par_err
  );
  modport master (
    output in_valid, in_data, in_last, out_ready, in_par_exp,
    input  in_ready, out_valid, out_red, out_count, out_trunc, out_par_err
  );
`else
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_red, out_count, out_trunc
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_red, out_count, out_trunc
  );
`endif

endinterface

// File: rtl/reduction_accumulator_word.sv
// Single-word AND/OR/XOR reduction; purely combinational.
module reduction_word #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             w_and,
  output logic             w_or,
  output logic             w_xor
);

  assign w_and = &data;
  assign w_or  = |data;
  assign w_xor = ^data;

endmodule

// File: rtl/reduction_accumulator.sv
// Folds a packet of words into AND/NAND/OR/NOR/XOR/XNOR, word count and truncation flag.
// Optional macro PARITY_CHECK_EN adds in_par_exp / out_par_err.
module reduction_accumulator
  import reduction_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  reduction_accumulator_if.slave  bus,
  output logic [0:0]              dbg_state
);

  localparam int CW = $clog2(MAX_WORDS + 1);

  logic [0:0]    state;
  logic          and_acc, or_acc, xor_acc;
  logic [CW-1:0] cnt;
  logic          w_and, w_or, w_xor;
  logic          and_nxt, or_nxt, xor_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          accept, close;
  logic [5:0]    red_q;
  logic [CW-1:0] count_q;
  logic          trunc_q;

  reduction_word #(.WIDTH(WIDTH)) u_word (
    .data  (bus.in_data),
    .w_and (w_and),
    .w_or  (w_or),
    .w_xor (w_xor)
  );

  assign and_nxt = and_acc & w_and;
  assign or_nxt  = or_acc | w_or;
  assign xor_nxt = xor_acc ^ w_xor;
  assign cnt_nxt = cnt + CW'(1);
  assign accept  = bus.in_valid && bus.in_ready;
  assign close   = bus.in_last || (cnt_nxt == CW'(MAX_WORDS));

  // Handshake outputs decode state only, so out_ready never reaches in_ready.
  assign bus.in_ready  = (state == ST_ACC);
  assign bus.out_valid = (state == ST_HOLD);
  assign bus.out_red   = red_q;
  assign bus.out_count = count_q;
  assign bus.out_trunc = trunc_q;
  assign dbg_state     = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_ACC;
      and_acc <= 1'b1;
      or_acc  <= 1'b0;
      xor_acc <= 1'b0;
      cnt     <= '0;
      red_q   <= RED_RST;
      count_q <= '0;
      trunc_q <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (accept) begin
            if (close) begin
              red_q   <= pack_red(and_nxt, or_nxt, xor_nxt);
              count_q <= cnt_nxt;
              trunc_q <= !bus.in_last;
              and_acc <= 1'b1;
              or_acc  <= 1'b0;
              xor_acc <= 1'b0;
              cnt     <= '0;
              state   <= ST_HOLD;
            end else begin
              and_acc <= and_nxt;
              or_acc  <= or_nxt;
              xor_acc <= xor_nxt;
              cnt     <= cnt_nxt;
            end
          end
        end
        default: begin
          if (bus.out_ready) state <= ST_ACC;
        end
      endcase
    end
  end

`ifdef PARITY_CHECK_EN
  logic par_err_q;

  assign bus.out_par_err = par_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else if (state == ST_ACC && accept && close) begin
      par_err_q <= (xor_nxt != bus.in_par_exp);
    end
  end
`endif

endmodule

// File: tb/tb_reduction_accumulator.sv
// Directed bench for reduction_accumulator with WIDTH=4, MAX_WORDS=4.
module tb_reduction_accumulator;

  localparam int WIDTH     = 4;
  localparam int MAX_WORDS = 4;
  localparam int CW        = $clog2(MAX_WORDS + 1);

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [5:0]       red;
    logic [CW-1:0]    count;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [0:0] dbg_state;
  int         pass_cnt;
  int         total_cnt;
  logic [6+CW:0] exp_q[$];
  vec_t       vecs[4];

  reduction_accumulator_if #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) bus();

  reduction_accumulator #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // driver: offer one word, return just after the accepting edge
  task automatic send_word(input logic [WIDTH-1:0] d, input logic last);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("send_timeout", 16'(bus.in_ready), 16'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic push_exp(input logic [5:0] red, input logic [CW-1:0] count, input logic trunc);
    exp_q.push_back({red, count, trunc});
  endtask

  // scoreboard: wait for a result, compare against the queue head, then take it
  task automatic collect(input string name);
    int guard;
    logic [6+CW:0] e;
    guard = 0;
    @(negedge clk);
    while (!bus.out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check({name, "_timeout"}, 16'(bus.out_valid), 16'd1);
    if (exp_q.size() == 0) begin
      check({name, "_unexpected"}, 16'(exp_q.size()), 16'd1);
    end else begin
      e = exp_q.pop_front();
      check({name, "_red"},   16'(bus.out_red),   16'(e[6+CW:1+CW]));
      check({name, "_count"}, 16'(bus.out_count), 16'(e[CW:1]));
      check({name, "_trunc"}, 16'(bus.out_trunc), 16'(e[0]));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    pass_cnt      = 0;
    total_cnt     = 0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
`ifdef PARITY_CHECK_EN
    bus.in_par_exp = 1'b0;
`endif

    vecs[0] = '{data: 4'b0000, red: 6'b010101, count: 3'd1};
    vecs[1] = '{data: 4'b0101, red: 6'b011001, count: 3'd1};
    vecs[2] = '{data: 4'b0111, red: 6'b011010, count: 3'd1};
    vecs[3] = '{data: 4'b1111, red: 6'b101001, count: 3'd1};

    apply_reset();
    check("rst_out_valid", 16'(bus.out_valid), 16'd0);
    check("rst_in_ready",  16'(bus.in_ready),  16'd1);
    check("rst_out_red",   16'(bus.out_red),   16'h15);
    check("rst_out_count", 16'(bus.out_count), 16'd0);
    check("rst_out_trunc", 16'(bus.out_trunc), 16'd0);
`ifdef PARITY_CHECK_EN
    check("rst_par_err",   16'(bus.out_par_err), 16'd0);
`endif

    // single-word packets
    for (int i = 0; i < 4; i++) begin
      push_exp(vecs[i].red, vecs[i].count, 1'b0);
      send_word(vecs[i].data, 1'b1);
      collect($sformatf("single%0d", i));
    end

    // three-word packet
    send_word(4'b1111, 1'b0);
    send_word(4'b1111, 1'b0);
    push_exp(6'b011010, 3'd3, 1'b0);
    send_word(4'b1110, 1'b1);
    collect("multi3");

    // six words, no in_last until the sixth: truncated at four, remainder forms a new packet
    for (int i = 0; i < 3; i++) send_word(4'b0001, 1'b0);
    push_exp(6'b011001, 3'd4, 1'b1);
    send_word(4'b0001, 1'b0);
    collect("trunc_a");
    send_word(4'b0001, 1'b0);
    push_exp(6'b011001, 3'd2, 1'b0);
    send_word(4'b0001, 1'b1);
    collect("trunc_b");

    // in_last on the MAX_WORDS-th word is not a truncation
    for (int i = 0; i < 3; i++) send_word(4'b1111, 1'b0);
    push_exp(6'b101001, 3'd4, 1'b0);
    send_word(4'b1111, 1'b1);
    collect("full_last");

    // stall in HOLD: outputs stable, no input acceptance
    send_word(4'b1111, 1'b1);
    check("lat_out_valid", 16'(bus.out_valid), 16'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d_in_ready", i),  16'(bus.in_ready),  16'd0);
      check($sformatf("hold%0d_out_valid", i), 16'(bus.out_valid), 16'd1);
      check($sformatf("hold%0d_red", i),       16'(bus.out_red),   16'h29);
      check($sformatf("hold%0d_count", i),     16'(bus.out_count), 16'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("hold_release_in_ready", 16'(bus.in_ready), 16'd1);

    // reset mid-packet discards the partial accumulation
    send_word(4'b0001, 1'b0);
    send_word(4'b0001, 1'b0);
    apply_reset();
    check("midrst_out_valid", 16'(bus.out_valid), 16'd0);
    check("midrst_out_red",   16'(bus.out_red),   16'h15);
    push_exp(6'b011010, 3'd1, 1'b0);
    send_word(4'b1000, 1'b1);
    collect("after_rst");

    // reset in HOLD drops the pending result
    send_word(4'b1111, 1'b1);
    apply_reset();
    check("holdrst_out_valid", 16'(bus.out_valid), 16'd0);
    check("holdrst_out_red",   16'(bus.out_red),   16'h15);
    check("holdrst_out_count", 16'(bus.out_count), 16'd0);

`ifdef PARITY_CHECK_EN
    bus.in_par_exp = 1'b0;
    send_word(4'b0011, 1'b0);
    push_exp(6'b011010, 3'd2, 1'b0);
    send_word(4'b0001, 1'b1);
    @(negedge clk);
    check("par_err_mismatch", 16'(bus.out_par_err), 16'd1);
    collect("par_a");
    bus.in_par_exp = 1'b1;
    send_word(4'b0011, 1'b0);
    push_exp(6'b011010, 3'd2, 1'b0);
    send_word(4'b0001, 1'b1);
    @(negedge clk);
    check("par_err_match", 16'(bus.out_par_err), 16'd0);
    collect("par_b");
`endif

    check("exp_q_drained", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
